// File: rtl/mux_2x1_arb_if.sv
// Bundle of the two requester channels and the downstream valid/ready channel of mux_2x1_arb.
// The arbiter uses the slave modport; the producers/consumer side uses the master modport.
interface mux_2x1_arb_if #(
  parameter int DATA_W = 8
);
  logic              req0;
  logic [DATA_W-1:0] i0;
  logic              gnt0;
  logic              req1;
  logic [DATA_W-1:0] i1;
  logic              gnt1;
  logic              s;
  logic [DATA_W-1:0] y;
  logic              y_valid;
  logic              y_ready;

  modport slave (
    input  req0, i0, req1, i1, y_ready,
    output gnt0, gnt1, s, y, y_valid
  );

  modport master (
    output req0, i0, req1, i1, y_ready,
    input  gnt0, gnt1, s, y, y_valid
  );
endinterface

// File: rtl/mux_2x1_arb.sv
// Two-requester burst arbiter driving a registered 2:1 mux output stage.
// Optional build macro MUX_ARB_FIXED_PRIO_EN: requester 0 always wins contention instead of round-robin.
module mux_2x1_arb #(
  parameter int DATA_W    = 8,
  parameter int MAX_BURST = 4
) (
  input  logic         clk,
  input  logic         rst,
  mux_2x1_arb_if.slave bus,
  output logic [1:0]   dbg_state
);

  localparam int               CNT_W    = $clog2(MAX_BURST + 1);
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  state_t            state;
  state_t            state_n;
  state_t            pick_both;
  state_t            tgt0;
  state_t            tgt1;
  logic [CNT_W-1:0]  cnt;
  logic              s_q;
  logic              y_valid_q;
  logic [DATA_W-1:0] y_q;
  logic              free;
  logic              gnt0;
  logic              gnt1;
  logic              xfer;
  logic              burst_end;
  logic              enter;

  // Handshake: a beat moves on gntk (reqk & slot free); y moves downstream on y_valid & y_ready.
  assign free      = !y_valid_q || bus.y_ready;
  assign gnt0      = (state == OWN0) && bus.req0 && free && !rst;
  assign gnt1      = (state == OWN1) && bus.req1 && free && !rst;
  assign xfer      = gnt0 || gnt1;
  assign burst_end = (cnt == CNT_LAST);

`ifdef MUX_ARB_FIXED_PRIO_EN
  assign pick_both = OWN0;

  always_comb begin
    tgt0 = IDLE;
    if (bus.req0) begin
      tgt0 = OWN0;
    end else if (bus.req1) begin
      tgt0 = OWN1;
    end
  end
`else
  logic last;

  assign pick_both = last ? OWN0 : OWN1;

  // Leaving OWN0 hands over to requester 1 whenever it is waiting.
  always_comb begin
    tgt0 = IDLE;
    if (bus.req1) begin
      tgt0 = OWN1;
    end else if (bus.req0) begin
      tgt0 = OWN0;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      last <= 1'b1;
    end else if (enter) begin
      last <= (state_n == OWN1);
    end
  end
`endif

  always_comb begin
    tgt1 = IDLE;
    if (bus.req0) begin
      tgt1 = OWN0;
    end else if (bus.req1) begin
      tgt1 = OWN1;
    end
  end

  always_comb begin
    state_n = state;
    enter   = 1'b0;
    unique case (state)
      IDLE: begin
        if (bus.req0 && bus.req1) begin
          state_n = pick_both;
          enter   = 1'b1;
        end else if (bus.req0) begin
          state_n = OWN0;
          enter   = 1'b1;
        end else if (bus.req1) begin
          state_n = OWN1;
          enter   = 1'b1;
        end
      end
      OWN0: begin
        if (!bus.req0 || (gnt0 && burst_end)) begin
          state_n = tgt0;
          enter   = (tgt0 != IDLE);
        end
      end
      OWN1: begin
        if (!bus.req1 || (gnt1 && burst_end)) begin
          state_n = tgt1;
          enter   = (tgt1 != IDLE);
        end
      end
      default: begin
        state_n = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state <= IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Entering an ownership period restarts the burst count, overriding the increment of a final beat.
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      s_q <= 1'b0;
    end else if (enter) begin
      cnt <= '0;
      s_q <= (state_n == OWN1);
    end else if (xfer) begin
      cnt <= cnt + CNT_W'(1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      y_q       <= '0;
      y_valid_q <= 1'b0;
    end else if (xfer) begin
      y_q       <= gnt1 ? bus.i1 : bus.i0;
      y_valid_q <= 1'b1;
    end else if (bus.y_ready) begin
      y_valid_q <= 1'b0;
    end
  end

  assign bus.gnt0    = gnt0;
  assign bus.gnt1    = gnt1;
  assign bus.s       = s_q;
  assign bus.y       = y_q;
  assign bus.y_valid = y_valid_q;
  assign dbg_state   = state;

endmodule

// File: tb/tb_mux_2x1_arb.sv
// Self-checking bench for mux_2x1_arb: scenario tasks with inline checks plus a beat scoreboard.
module tb_mux_2x1_arb;
  localparam int DATA_W    = 8;
  localparam int MAX_BURST = 4;

  logic              clk = 1'b0;
  logic              rst;
  logic [1:0]        dbg_state;
  logic [DATA_W-1:0] exp_q[$];
  logic [DATA_W-1:0] exp_v;
  int                n_checks = 0;
  int                n_fail   = 0;
  bit                auto_data;
  bit                g0;
  bit                g1;
  int                n0;
  int                n1;

  mux_2x1_arb_if #(.DATA_W(DATA_W)) bus ();

  mux_2x1_arb #(.DATA_W(DATA_W), .MAX_BURST(MAX_BURST)) dut (
    .clk       (clk),
    .rst       (rst),
    .bus       (bus),
    .dbg_state (dbg_state)
  );

  // Clock / reset block
  always #5 clk = ~clk;

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Scoreboard: push on an accepted beat, pop when downstream consumes y.
  always @(negedge clk) begin
    if (rst) begin
      exp_q.delete();
    end else begin
      if (bus.y_valid && bus.y_ready) begin
        n_checks++;
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL sb_underflow: y=%h consumed, no beat expected", bus.y);
        end else begin
          exp_v = exp_q.pop_front();
          if (bus.y !== exp_v) begin
            n_fail++;
            $display("FAIL sb_data: y=%h expected %h", bus.y, exp_v);
          end
        end
      end
      if (bus.gnt0) exp_q.push_back(bus.i0);
      if (bus.gnt1) exp_q.push_back(bus.i1);
    end
  end

  // Driver: advance one cycle; producers step their data after each accepted beat.
  task automatic nxt();
    #1;
    g0 = bus.gnt0;
    g1 = bus.gnt1;
    @(posedge clk);
    #1;
    if (auto_data) begin
      if (g0) begin
        n0++;
        bus.i0 = 8'h10 + DATA_W'(n0 % 4);
      end
      if (g1) begin
        n1++;
        bus.i1 = 8'h20 + DATA_W'(n1 % 4);
      end
    end
  endtask

  task automatic do_reset();
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.y_ready = 1'b1;
    auto_data = 1'b0;
    n0 = 0;
    n1 = 0;
    nxt();
    nxt();
    rst = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    bus.y_ready = 1'b1;
    auto_data = 1'b0;
    for (int i = 0; i < 2; i++) begin
      bus.req0 = 1'($urandom_range(0, 1));
      bus.req1 = 1'($urandom_range(0, 1));
      bus.i0   = DATA_W'($urandom_range(0, 255));
      bus.i1   = DATA_W'($urandom_range(0, 255));
      #1;
      n_checks++;
      if (bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
        n_fail++;
        $display("FAIL reset_gnt: gnt0=%b gnt1=%b expected 0 0", bus.gnt0, bus.gnt1);
      end
      nxt();
    end
    n_checks++;
    if (bus.y !== 8'h00) begin n_fail++; $display("FAIL reset_y: got %h expected 00", bus.y); end
    n_checks++;
    if (bus.y_valid !== 1'b0) begin n_fail++; $display("FAIL reset_y_valid: got %b expected 0", bus.y_valid); end
    n_checks++;
    if (bus.s !== 1'b0) begin n_fail++; $display("FAIL reset_s: got %b expected 0", bus.s); end
    n_checks++;
    if (dbg_state !== 2'd0) begin n_fail++; $display("FAIL reset_state: got %0d expected 0", dbg_state); end
    rst = 1'b0;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    nxt();
  endtask

  task automatic test_single();
    bus.y_ready = 1'b1;
    bus.i0 = 8'hA5;
    bus.req0 = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL single_no_early_gnt: gnt0=%b expected 0", bus.gnt0); end
    nxt();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL single_gnt0: got %b expected 1", bus.gnt0); end
    n_checks++;
    if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL single_state: got %0d expected 1", dbg_state); end
    nxt();
    n_checks++;
    if (bus.y !== 8'hA5 || bus.y_valid !== 1'b1 || bus.s !== 1'b0) begin
      n_fail++;
      $display("FAIL single_out: y=%h y_valid=%b s=%b expected a5 1 0", bus.y, bus.y_valid, bus.s);
    end
    bus.req0 = 1'b0;
    nxt();
    n_checks++;
    if (dbg_state !== 2'd0 || bus.y_valid !== 1'b0) begin
      n_fail++;
      $display("FAIL single_idle: state=%0d y_valid=%b expected 0 0", dbg_state, bus.y_valid);
    end
    nxt();
  endtask

  task automatic test_contention();
    int gi;
    int yi;
    logic              eo;
    logic [DATA_W-1:0] ey;
    do_reset();
    auto_data = 1'b1;
    bus.i0 = 8'h10;
    bus.i1 = 8'h20;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    gi = 0;
    yi = 0;
    nxt();
    for (int c = 0; c < 24; c++) begin
      #1;
`ifdef MUX_ARB_FIXED_PRIO_EN
      eo = 1'b0;
      ey = 8'h10 + DATA_W'(yi % 4);
`else
      eo = ((gi / MAX_BURST) % 2) == 1;
      ey = (((yi / MAX_BURST) % 2) == 1 ? 8'h20 : 8'h10) + DATA_W'(yi % 4);
`endif
      n_checks++;
      if ((bus.gnt0 || bus.gnt1) !== 1'b1) begin
        n_fail++;
        $display("FAIL cont_no_idle: cycle %0d gnt0=%b gnt1=%b expected one grant", c, bus.gnt0, bus.gnt1);
      end
      n_checks++;
      if (bus.s !== eo || bus.gnt1 !== eo) begin
        n_fail++;
        $display("FAIL cont_owner: grant %0d s=%b gnt1=%b expected %b", gi, bus.s, bus.gnt1, eo);
      end
      gi++;
      if (c > 0) begin
        n_checks++;
        if (bus.y_valid !== 1'b1 || bus.y !== ey) begin
          n_fail++;
          $display("FAIL cont_y: beat %0d y=%h y_valid=%b expected %h 1", yi, bus.y, bus.y_valid, ey);
        end
        yi++;
      end
      nxt();
    end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    auto_data = 1'b0;
    repeat (3) nxt();
  endtask

  task automatic test_backpressure();
    do_reset();
    auto_data = 1'b1;
    bus.i0 = 8'h10;
    bus.req0 = 1'b1;
    nxt();
    nxt();
    bus.y_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      #1;
      n_checks++;
      if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL bp_gnt0: cycle %0d got %b expected 0", c, bus.gnt0); end
      n_checks++;
      if (bus.y !== 8'h10 || bus.y_valid !== 1'b1) begin
        n_fail++;
        $display("FAIL bp_hold: cycle %0d y=%h y_valid=%b expected 10 1", c, bus.y, bus.y_valid);
      end
      n_checks++;
      if (dbg_state !== 2'd1) begin n_fail++; $display("FAIL bp_state: got %0d expected 1", dbg_state); end
      nxt();
    end
    bus.y_ready = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1) begin n_fail++; $display("FAIL bp_release_gnt0: got %b expected 1", bus.gnt0); end
    nxt();
    n_checks++;
    if (bus.y !== 8'h11 || bus.y_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_resume: y=%h y_valid=%b expected 11 1", bus.y, bus.y_valid);
    end
    repeat (6) nxt();
    bus.req0 = 1'b0;
    auto_data = 1'b0;
    repeat (3) nxt();
  endtask

  task automatic test_req_drop();
    do_reset();
    auto_data = 1'b1;
    bus.i1 = 8'h20;
    bus.req1 = 1'b1;
    nxt();
    #1;
    n_checks++;
    if (dbg_state !== 2'd2 || bus.s !== 1'b1 || bus.gnt1 !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_own1: state=%0d s=%b gnt1=%b expected 2 1 1", dbg_state, bus.s, bus.gnt1);
    end
    nxt();
    nxt();
    n_checks++;
    if (bus.y !== 8'h21) begin n_fail++; $display("FAIL drop_second_beat: y=%h expected 21", bus.y); end
    bus.req1 = 1'b0;
    #1;
    n_checks++;
    if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL drop_gnt1: got %b expected 0", bus.gnt1); end
    nxt();
    n_checks++;
    if (dbg_state !== 2'd0 || bus.s !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_idle: state=%0d s=%b expected 0 1", dbg_state, bus.s);
    end
    auto_data = 1'b0;
    bus.i0 = 8'h5A;
    bus.req0 = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b0) begin n_fail++; $display("FAIL drop_idle_gnt0: got %b expected 0", bus.gnt0); end
    nxt();
    #1;
    n_checks++;
    if (bus.s !== 1'b0 || bus.gnt0 !== 1'b1) begin
      n_fail++;
      $display("FAIL drop_req0: s=%b gnt0=%b expected 0 1", bus.s, bus.gnt0);
    end
    nxt();
    n_checks++;
    if (bus.y !== 8'h5A) begin n_fail++; $display("FAIL drop_req0_y: y=%h expected 5a", bus.y); end
    bus.req0 = 1'b0;
    repeat (2) nxt();
  endtask

  task automatic test_reset_mid();
    do_reset();
    auto_data = 1'b1;
    bus.i1 = 8'h20;
    bus.req1 = 1'b1;
    nxt();
    nxt();
    rst = 1'b1;
    #1;
    n_checks++;
    if (bus.gnt1 !== 1'b0) begin n_fail++; $display("FAIL mid_rst_gnt1: got %b expected 0", bus.gnt1); end
    nxt();
    n_checks++;
    if (bus.y_valid !== 1'b0 || dbg_state !== 2'd0 || bus.gnt0 !== 1'b0 || bus.gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_clear: y_valid=%b state=%0d gnt0=%b gnt1=%b expected 0 0 0 0",
               bus.y_valid, dbg_state, bus.gnt0, bus.gnt1);
    end
    rst = 1'b0;
    auto_data = 1'b0;
    bus.i0 = 8'h33;
    bus.i1 = 8'h44;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    nxt();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0 || bus.s !== 1'b0) begin
      n_fail++;
      $display("FAIL mid_rst_first: gnt0=%b gnt1=%b s=%b expected 1 0 0", bus.gnt0, bus.gnt1, bus.s);
    end
    nxt();
    n_checks++;
    if (bus.y !== 8'h33) begin n_fail++; $display("FAIL mid_rst_y: y=%h expected 33", bus.y); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (2) nxt();

    // Reset while requester 0 owns the mux: the round-robin pointer must return to its reset value.
    do_reset();
    bus.i0 = 8'h66;
    bus.req0 = 1'b1;
    nxt();
    nxt();
    rst = 1'b1;
    nxt();
    rst = 1'b0;
    bus.i0 = 8'h77;
    bus.i1 = 8'h88;
    bus.req0 = 1'b1;
    bus.req1 = 1'b1;
    nxt();
    #1;
    n_checks++;
    if (bus.gnt0 !== 1'b1 || bus.gnt1 !== 1'b0) begin
      n_fail++;
      $display("FAIL rst_last: gnt0=%b gnt1=%b expected 1 0", bus.gnt0, bus.gnt1);
    end
    nxt();
    n_checks++;
    if (bus.y !== 8'h77) begin n_fail++; $display("FAIL rst_last_y: y=%h expected 77", bus.y); end
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    repeat (3) nxt();
  endtask

  initial begin
    rst = 1'b1;
    bus.req0 = 1'b0;
    bus.req1 = 1'b0;
    bus.i0 = '0;
    bus.i1 = '0;
    bus.y_ready = 1'b1;
    auto_data = 1'b0;
    n0 = 0;
    n1 = 0;
    test_reset();
    test_single();
    test_contention();
    test_backpressure();
    test_req_drop();
    test_reset_mid();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL sb_leftover: %0d beats never delivered, expected 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
